// File: rtl/uart_frame_crc.sv
// UART receive framing stage: LEN, payload, CRC_HI, CRC_LO.
// Forwards payload and checks each frame with bit-serial CRC-16/CCITT.
module uart_frame_crc #(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CRC_HI,
    CRC_LO
  } state_t;

  localparam logic [7:0]  MAXL = 8'(MAX_LEN);
  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] r;
  logic [15:0] r_next;
  logic [7:0]  sh;
  logic [7:0]  cur;
  logic [7:0]  rem;
  logic [3:0]  scnt;
  logic [15:0] tcnt;
  logic        accept;
  logic        last;
  logic        stall;
  logic        tick;

  assign in_ready = ~rst & (scnt == 4'd0) & ~out_valid;
  assign accept   = in_valid & in_ready;
  assign last     = scnt == 4'd1;
  assign stall    = out_valid & ~out_ready;
  assign busy     = state != IDLE;

  // Idle cycles inside a frame; shifting and back-pressure are excluded.
  assign tick = (state != IDLE) & (scnt == 4'd0)
              & ~accept & ~stall;

  // One augmented CRC step on the MSB of the shift register.
  assign r_next = {r[14:0], sh[7]}
                ^ (r[15] ? 16'h1021 : 16'h0000);

  // Byte accept, bit-serial CRC, frame state and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      r          <= 16'h0000;
      sh         <= 8'h00;
      cur        <= 8'h00;
      rem        <= 8'h00;
      scnt       <= 4'd0;
      tcnt       <= 16'h0000;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        sh   <= in_data;
        cur  <= in_data;
        scnt <= 4'd8;
        tcnt <= 16'h0000;
        if (state == IDLE) begin
          r <= 16'h0000;
        end
        if (state == PAYLOAD) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
          rem       <= rem - 8'd1;
        end
      end else if (scnt != 4'd0) begin
        sh   <= {sh[6:0], 1'b0};
        r    <= r_next;
        scnt <= scnt - 4'd1;
        if (last) begin
          unique case (state)
            IDLE: begin
              if (cur > MAXL) begin
                frame_done <= 1'b1;
              end else if (cur == 8'd0) begin
                state <= CRC_HI;
              end else begin
                rem   <= cur;
                state <= PAYLOAD;
              end
            end
            PAYLOAD: begin
              if (rem == 8'd0) begin
                state <= CRC_HI;
              end
            end
            CRC_HI: begin
              state <= CRC_LO;
            end
            CRC_LO: begin
              frame_done <= 1'b1;
              frame_ok   <= r_next == 16'h0000;
              state      <= IDLE;
            end
          endcase
        end
      end else if (tick) begin
        if (tcnt == TLIM) begin
          frame_done <= 1'b1;
          state      <= IDLE;
          tcnt       <= 16'h0000;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_crc.sv
// Scoreboard bench for uart_frame_crc.
// Small MAX_LEN/TIMEOUT so the boundary cases are reachable quickly.
module tb_uart_frame_crc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       frame_done;
  logic       frame_ok;
  logic       busy;

  uart_frame_crc #(
    .MAX_LEN(4),
    .TIMEOUT(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic ok;
    int   at;
  } fexp_t;

  fexp_t      fq[$];
  logic [7:0] oq[$];
  logic [7:0] mx;
  fexp_t      mf;

  // Reference CRC: direct (non-augmented) XMODEM update.
  function automatic logic [15:0] crc_upd(
    input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  // Scoreboard monitor, sampled 1ns before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        if (oq.size() == 0) begin
          bad++;
          $display("FAIL out_extra got=%h expected none",
                   out_data);
        end else begin
          mx = oq.pop_front();
          if (out_data !== mx) begin
            bad++;
            $display("FAIL out_data got=%h expected=%h",
                     out_data, mx);
          end
        end
      end
      if (frame_done) begin
        total++;
        if (fq.size() == 0) begin
          bad++;
          $display("FAIL done_extra ok=%b cyc=%0d",
                   frame_ok, cyc);
        end else begin
          mf = fq.pop_front();
          if (frame_ok !== mf.ok) begin
            bad++;
            $display("FAIL frame_ok got=%b expected=%b",
                     frame_ok, mf.ok);
          end
          if (mf.at >= 0) begin
            total++;
            if (cyc !== mf.at) begin
              bad++;
              $display("FAIL done_cycle got=%0d expected=%0d",
                       cyc, mf.at);
            end
          end
        end
      end
    end
  end

  // Present a byte; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, output int t);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_wait byte=%h got=stuck expected=ready",
               b);
    end
    t = cyc;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!frame_done) begin
      bad++;
      $display("FAIL done_wait got=none expected=pulse");
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_at_done got=%b expected=0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_data, frame_done,
         frame_ok, busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_state got=%b%b%h%b%b%b expected=0",
               in_ready, out_valid, out_data,
               frame_done, frame_ok, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got=%b expected=1",
               in_ready);
    end
  endtask

  task automatic test_one_byte();
    int t0, t1, t2, t3;
    oq.push_back(8'hA3);
    send(8'h01, t0);
    send(8'hA3, t1);
    total++;
    if (!(out_valid === 1'b1 && out_data === 8'hA3)) begin
      bad++;
      $display("FAIL payload_latency got=%b/%h expected=1/a3",
               out_valid, out_data);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_frame got=%b expected=1", busy);
    end
    total++;
    if (t1 - t0 !== 9) begin
      bad++;
      $display("FAIL cadence got=%0d expected=9", t1 - t0);
    end
    send(8'hB6, t2);
    send(8'hB8, t3);
    in_valid = 1'b0;
    fq.push_back('{1'b1, t3 + 9});
    wait_done();
  endtask

  task automatic test_bad_crc();
    int t;
    oq.push_back(8'hA3);
    send(8'h01, t);
    send(8'hA3, t);
    send(8'hB6, t);
    send(8'hB9, t);
    in_valid = 1'b0;
    fq.push_back('{1'b0, t + 9});
    wait_done();
  endtask

  task automatic test_zero_len();
    int t;
    send(8'h00, t);
    send(8'h00, t);
    send(8'h00, t);
    in_valid = 1'b0;
    fq.push_back('{1'b1, t + 9});
    wait_done();
  endtask

  task automatic test_oversize();
    int t;
    send(8'h05, t);
    in_valid = 1'b0;
    fq.push_back('{1'b0, t + 9});
    wait_done();
    oq.push_back(8'hA3);
    send(8'h01, t);
    send(8'hA3, t);
    send(8'hB6, t);
    send(8'hB8, t);
    in_valid = 1'b0;
    fq.push_back('{1'b1, t + 9});
    wait_done();
  endtask

  task automatic test_backpressure();
    int t;
    logic [15:0] c;
    c = crc_upd(16'h0000, 8'h02);
    c = crc_upd(c, 8'h11);
    c = crc_upd(c, 8'h22);
    oq.push_back(8'h11);
    oq.push_back(8'h22);
    send(8'h02, t);
    out_ready = 1'b0;
    send(8'h11, t);
    in_valid = 1'b1;
    in_data  = 8'h22;
    for (int i = 0; i < 50; i++) begin
      total++;
      if (!(out_valid === 1'b1 && out_data === 8'h11 &&
            in_ready === 1'b0 && frame_done === 1'b0)) begin
        bad++;
        $display("FAIL stall cyc=%0d got=%b/%h/%b/%b exp=1/11/0/0",
                 i, out_valid, out_data, in_ready, frame_done);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(8'h22, t);
    send(c[15:8], t);
    send(c[7:0], t);
    in_valid = 1'b0;
    fq.push_back('{1'b1, t + 9});
    wait_done();
  endtask

  task automatic test_timeout();
    int t;
    oq.push_back(8'hAA);
    send(8'h03, t);
    send(8'hAA, t);
    in_valid = 1'b0;
    fq.push_back('{1'b0, t + 29});
    wait_done();
  endtask

  task automatic test_reset_mid();
    int t;
    send(8'h03, t);
    out_ready = 1'b0;
    send(8'h11, t);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_data, frame_done,
         frame_ok, busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_mid got=%b%b%h%b%b%b expected=0",
               in_ready, out_valid, out_data,
               frame_done, frame_ok, busy);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    oq.push_back(8'hA3);
    send(8'h01, t);
    send(8'hA3, t);
    send(8'hB6, t);
    send(8'hB8, t);
    in_valid = 1'b0;
    fq.push_back('{1'b1, t + 9});
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_one_byte();
    test_bad_crc();
    test_zero_len();
    test_oversize();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    repeat (12) @(negedge clk);
    total++;
    if (oq.size() != 0 || fq.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d/%0d expected=0/0",
               oq.size(), fq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_crc.md
# uart_frame_crc

Receive-side framing stage that sits directly downstream of the UART receiver byte interface and feeds received payload to the rest of the SoC. It consumes a byte stream of the form LEN, LEN payload bytes, CRC_HI, CRC_LO. It forwards payload bytes, checks each frame with a bit-serial CRC-16/CCITT (poly x^16+x^12+x^5+1, 0x1021, init 0, MSB first, no reflection, no final XOR), and reports pass/fail per frame.

## Interface
- MAX_LEN, 64: largest accepted LEN value; legal range is 0..255.
- TIMEOUT, 65535: number of idle clk cycles allowed between bytes inside a frame before the frame is aborted.
- clk  input  1  system clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a received UART byte is available.
- in_data  input  8  the received byte.
- in_ready  output  1  the block accepts the byte this cycle.
- out_valid  output  1  a payload byte is held on out_data.
- out_data  output  8  payload byte.
- out_ready  input  1  the consumer takes the byte this cycle.
- frame_done  output  1  one-cycle pulse at the end of a frame or an abort.
- frame_ok  output  1  valid only with frame_done; 1 means CRC good and no error.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE (wait for LEN), PAYLOAD, CRC_HI, CRC_LO.
- **Shift counter:** a 4-bit shift counter runs orthogonally to the state. A value of 0 means not shifting.
- **Byte accept:** a byte is accepted when in_valid & in_ready. Every accepted byte, including LEN and both CRC bytes, is loaded into a shift register. It is then shifted into the CRC over 8 cycles, MSB first.
- **CRC step, per bit b:**
  - fb = r[15]
  - r = {r[14:0], b} ^ (fb ? 16'h1021 : 0)
  - This is the augmented form, so a good frame leaves r == 0 after the last CRC_LO bit.
- **in_ready:** in_ready = ~rst & (shift counter == 0) & ~out_valid.
- **IDLE accepts LEN:**
  - r is cleared to 0, then LEN is shifted in.
  - LEN > MAX_LEN: after LEN is shifted, pulse frame_done with frame_ok=0 and stay in IDLE. Following bytes are parsed as a new LEN; no resync hunting is done.
  - LEN == 0: go to CRC_HI.
  - Otherwise: load the remaining-byte counter with LEN and go to PAYLOAD.
- **PAYLOAD:**
  - Each accepted byte is copied to out_data and out_valid is set on the next cycle.
  - The remaining-byte counter decrements; when it reaches 0, go to CRC_HI.
- **CRC_HI and CRC_LO:**
  - Each accepts one byte. The CRC bytes are shifted into the CRC but never forwarded.
  - After the 8th bit of CRC_LO: pulse frame_done, with frame_ok = (r_next == 0). Return to IDLE.
- **Output buffer:** out_valid stays set until out_valid & out_ready. Neither out_valid nor out_data changes while it is stalled.
- **Timeout:**
  - Active in PAYLOAD, CRC_HI and CRC_LO.
  - A counter increments each cycle with shift counter == 0 and no byte accepted. It clears on each accept.
  - Cycles with out_valid high and out_ready low (back-pressure) do not count.
  - When the count reaches TIMEOUT: pulse frame_done with frame_ok=0 and go to IDLE. Any held out_valid byte is still delivered.
- **Reset mid-frame:** discards everything. Reset values:
  - state = IDLE, r = 0, shift counter = 0, timeout counter = 0
  - in_ready = 0 while rst is high
  - out_valid = 0, out_data = 0, frame_done = 0, frame_ok = 0, busy = 0

## Timing
- **Byte cadence:**
  - A byte is accepted in cycle t; bits are shifted in cycles t+1..t+8.
  - in_ready is low in cycles t+1..t+8, and rises no earlier than t+9.
  - Sustained rate is 1 byte per 9 cycles.
- **Payload latency:** out_valid rises in cycle t+1 for a byte accepted in cycle t.
- **End of frame:** frame_done is high for exactly one cycle, t+9, where t is the CRC_LO accept. busy falls in the same cycle t+9.
- **Oversize LEN:** frame_done pulses in cycle t+9 after the LEN accept.
- **Zero-length frame:** LEN=0 goes straight to CRC_HI after the LEN shift; no out_valid is produced for the frame.
- **Simultaneous events:** a timeout cannot coincide with an accept, because accept takes priority and clears the counter.
- **No drops:** in_valid held while in_ready is low must not lose data.

## Test plan
- **Good frame, one byte:** send 01 A3 B6 B8 with out_ready=1 → one out byte A3, then frame_done=1 with frame_ok=1 nine cycles after B8 is accepted.
- **Corrupted CRC:** send 01 A3 B6 B9 → A3 is forwarded, then frame_done with frame_ok=0.
- **Zero-length frame:** send 00 00 00 → no out_valid, then frame_done with frame_ok=1.
- **Oversize LEN:** with MAX_LEN=4, send 05 → frame_done with frame_ok=0 nine cycles later. The next bytes 01 A3 B6 B8 then pass with frame_ok=1.
- **Back-pressure:** send 02 11 22 plus the correct CRC, holding out_ready=0 for 50 cycles after 11 appears → out_data stays 11, in_ready stays low and no timeout occurs (TIMEOUT=20). Both bytes then arrive in order and frame_ok=1.
- **Timeout and reset:**
  - With TIMEOUT=20, send 03 AA and then idle → frame_done with frame_ok=0 exactly 20 idle cycles after the AA shift completes, and busy=0.
  - Separately, assert rst mid-payload → all outputs return to their reset values on the next cycle.
